// File: rtl/his_pingpong_ctrl_pkg.sv
// Shared constants, FSM encodings and a width helper for the dToF histogram
// ping-pong controller. The default geometry matches the production sensor;
// instances override it through named parameters.
package his_pingpong_ctrl_pkg;

    localparam int unsigned HIS_NB        = 4;      // bin index width
    localparam int unsigned HIS_BIN_NUM   = 10;     // bins per pixel histogram
    localparam int unsigned HIS_PIXEL_NUM = 200;    // pixels per RAM bank
    localparam int unsigned HIS_DATA_NUM  = 2;      // timestamps per pixel per acquisition
    localparam int unsigned HIS_ACQ_NUM   = 33333;  // acquisitions per frame

    // Write-side FSM encodings
    localparam logic [1:0] W_INIT = 2'd0;
    localparam logic [1:0] W_ACQ  = 2'd1;
    localparam logic [1:0] W_WAIT = 2'd2;

    // Read-side FSM encodings
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_READ  = 2'd1;
    localparam logic [1:0] R_CLEAR = 2'd2;

    // Ceiling log2, never below 1 so that single-value counters still get a bit.
    function automatic int unsigned his_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/his_pingpong_ctrl_if.sv
// Bus bundle between the ping-pong controller and its neighbours.
//   TDC side      : tdc_valid, tdc_bin (in)  / tdc_ready (out)
//   Increment port: wr_en, wr_bank, wr_addr
//   Readout port  : rd_valid, rd_bank, rd_addr, rd_last (out) / rd_ready (in)
//   Clear port    : clr_en, clr_mask, clr_addr
// master = controller side, slave = environment side.
interface his_pingpong_ctrl_if
    import his_pingpong_ctrl_pkg::*;
#(
    parameter int unsigned NB = HIS_NB,
    parameter int unsigned AW = his_clog2(HIS_PIXEL_NUM * HIS_BIN_NUM)
);
    logic          tdc_valid;
    logic [NB-1:0] tdc_bin;
    logic          tdc_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          rd_last;
    logic          clr_en;
    logic [1:0]    clr_mask;
    logic [AW-1:0] clr_addr;

    modport master (
        input  tdc_valid, tdc_bin, rd_ready,
        output tdc_ready, wr_en, wr_bank, wr_addr,
               rd_valid, rd_bank, rd_addr, rd_last,
               clr_en, clr_mask, clr_addr
    );

    modport slave (
        output tdc_valid, tdc_bin, rd_ready,
        input  tdc_ready, wr_en, wr_bank, wr_addr,
               rd_valid, rd_bank, rd_addr, rd_last,
               clr_en, clr_mask, clr_addr
    );
endinterface

// File: rtl/his_pingpong_ctrl_addr_seq.sv
// his_addr_seq: sweeps addr 0..DEPTH-1, one step per cycle in which adv is high.
//   clk, res : clock, asynchronous active-high reset
//   start    : (re)start the sweep at address 0
//   adv      : advance the current address
//   addr     : current address (0 when idle)
//   active   : sweep in progress
//   last     : active and addr == DEPTH-1
module his_addr_seq #(
    parameter int unsigned DEPTH = 20,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          adv,
    output logic [AW-1:0] addr,
    output logic          active,
    output logic          last
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    assign last = active && (addr == LAST_ADDR);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            addr   <= '0;
            active <= 1'b0;
        end else if (start) begin
            addr   <= '0;
            active <= 1'b1;
        end else if (active && adv) begin
            if (last) begin
                addr   <= '0;
                active <= 1'b0;
            end else begin
                addr <= addr + AW'(1);
            end
        end
    end
endmodule

// File: rtl/his_pingpong_ctrl.sv
// his_pingpong_ctrl: ping-pong scheduler for two dToF histogram banks.
// Accepts TDC bins into bank his_num, swaps banks at frame end, streams the
// finished bank out as read addresses and then clears it.
//   clk, res   : clock, asynchronous active-high reset
//   bus        : TDC / increment / readout / clear signals (master side)
//   his_num    : bank currently under acquisition
//   frame_done : one-cycle pulse after each bank swap
//   err_bin    : sticky, an out-of-range bin was accepted
module his_pingpong_ctrl
    import his_pingpong_ctrl_pkg::*;
#(
    parameter int unsigned NB        = HIS_NB,
    parameter int unsigned BIN_NUM   = HIS_BIN_NUM,
    parameter int unsigned PIXEL_NUM = HIS_PIXEL_NUM,
    parameter int unsigned DATA_NUM  = HIS_DATA_NUM,
    parameter int unsigned ACQ_NUM   = HIS_ACQ_NUM
) (
    input  logic                   clk,
    input  logic                   res,
    his_pingpong_ctrl_if.master    bus,
    output logic                   his_num,
    output logic                   frame_done,
    output logic                   err_bin
);
    localparam int unsigned DEPTH = PIXEL_NUM * BIN_NUM;
    localparam int unsigned AW    = his_clog2(DEPTH);
    localparam int unsigned AQW   = his_clog2(ACQ_NUM);
    localparam int unsigned DW    = his_clog2(DATA_NUM);
    localparam int unsigned PW    = his_clog2(PIXEL_NUM);

    logic [1:0]     w_state;
    logic [1:0]     r_state;
    logic [DW-1:0]  in_cnt;
    logic [PW-1:0]  pix_cnt;
    logic [AQW-1:0] acq_cnt;
    logic           wr_en_q;
    logic [AW-1:0]  wr_addr_q;

    logic           rd_active, rd_last_w, clr_active, clr_last_w;
    logic [AW-1:0]  rd_addr_w, clr_addr_w;

    logic accept, bin_ok, in_last, pix_last, acq_last, frame_end;
    logic swap, init_start, rd_done;

    assign accept     = bus.tdc_valid && bus.tdc_ready;
    assign bin_ok     = 32'(bus.tdc_bin) < BIN_NUM;
    assign in_last    = in_cnt  == DW'(DATA_NUM - 1);
    assign pix_last   = pix_cnt == PW'(PIXEL_NUM - 1);
    assign acq_last   = acq_cnt == AQW'(ACQ_NUM - 1);
    assign frame_end  = in_last && pix_last && acq_last;
    assign swap       = (w_state == W_WAIT) && (r_state == R_IDLE);
    // The clear sweeper is idle on entry to W_INIT; it is started the first
    // cycle out of reset so that every output is 0 while res is held.
    assign init_start = (w_state == W_INIT) && !clr_active;
    assign rd_done    = rd_last_w && bus.rd_ready;

    his_addr_seq #(.DEPTH(DEPTH), .AW(AW)) u_rd_seq (
        .clk    (clk),
        .res    (res),
        .start  (swap),
        .adv    (bus.rd_ready),
        .addr   (rd_addr_w),
        .active (rd_active),
        .last   (rd_last_w)
    );

    // Shared by the power-on clear of both banks and the post-readout clear.
    his_addr_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr_seq (
        .clk    (clk),
        .res    (res),
        .start  (init_start || rd_done),
        .adv    (1'b1),
        .addr   (clr_addr_w),
        .active (clr_active),
        .last   (clr_last_w)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            w_state    <= W_INIT;
            in_cnt     <= '0;
            pix_cnt    <= '0;
            acq_cnt    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            his_num    <= 1'b0;
            frame_done <= 1'b0;
            err_bin    <= 1'b0;
        end else begin
            wr_en_q    <= accept && bin_ok;
            frame_done <= swap;
            if (accept) begin
                wr_addr_q <= AW'(pix_cnt) * AW'(BIN_NUM) + AW'(bus.tdc_bin);
                if (!bin_ok) begin
                    err_bin <= 1'b1;
                end
                if (in_last) begin
                    in_cnt <= '0;
                    if (pix_last) begin
                        pix_cnt <= '0;
                        acq_cnt <= acq_last ? '0 : acq_cnt + AQW'(1);
                    end else begin
                        pix_cnt <= pix_cnt + PW'(1);
                    end
                end else begin
                    in_cnt <= in_cnt + DW'(1);
                end
            end
            case (w_state)
                W_INIT: if (clr_last_w) w_state <= W_ACQ;
                W_ACQ:  if (accept && frame_end) w_state <= W_WAIT;
                W_WAIT: if (swap) begin
                    w_state <= W_ACQ;
                    his_num <= ~his_num;
                end
                default: w_state <= W_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= R_IDLE;
        end else begin
            case (r_state)
                R_IDLE:  if (swap) r_state <= R_READ;
                R_READ:  if (rd_done) r_state <= R_CLEAR;
                R_CLEAR: if (clr_last_w) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.tdc_ready = (w_state == W_ACQ);
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_bank   = his_num;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.rd_valid  = rd_active;
    // Qualified by rd_active so the readout port is all-zero when idle.
    assign bus.rd_bank   = rd_active & ~his_num;
    assign bus.rd_addr   = rd_addr_w;
    assign bus.rd_last   = rd_last_w;
    assign bus.clr_en    = clr_active;
    assign bus.clr_addr  = clr_addr_w;
    assign bus.clr_mask  = !clr_active          ? 2'b00 :
                           (w_state == W_INIT)  ? 2'b11 :
                           his_num              ? 2'b01 : 2'b10;
endmodule

// File: tb/tb_his_pingpong_ctrl.sv
module tb_his_pingpong_ctrl;
    localparam int unsigned NB        = 4;
    localparam int unsigned BIN_NUM   = 10;
    localparam int unsigned PIXEL_NUM = 2;
    localparam int unsigned DATA_NUM  = 2;
    localparam int unsigned ACQ_NUM   = 3;
    localparam int unsigned DEPTH     = 20;
    localparam int unsigned AW        = 5;

    logic clk = 1'b0;
    logic res = 1'b1;
    logic his_num, frame_done, err_bin;

    his_pingpong_ctrl_if #(.NB(NB), .AW(AW)) bus();

    his_pingpong_ctrl #(
        .NB(NB), .BIN_NUM(BIN_NUM), .PIXEL_NUM(PIXEL_NUM),
        .DATA_NUM(DATA_NUM), .ACQ_NUM(ACQ_NUM)
    ) dut (
        .clk(clk), .res(res), .bus(bus),
        .his_num(his_num), .frame_done(frame_done), .err_bin(err_bin)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard queues. rd/clr entries: tag<<24 | bank-or-mask<<16 | addr.
    int unsigned wr_q[$], rd_q[$], clr_q[$], fd_q[$];
    int unsigned m_bank, m_in, m_pix, m_acq, frm, fd_seen;
    int unsigned e;
    logic fd_prev = 1'b0;

    function automatic logic [31:0] outs();
        return 32'({bus.tdc_ready, bus.wr_en, bus.wr_bank, bus.wr_addr,
                    bus.rd_valid, bus.rd_bank, bus.rd_addr, bus.rd_last,
                    bus.clr_en, bus.clr_mask, bus.clr_addr,
                    his_num, frame_done, err_bin});
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        wr_q.delete(); rd_q.delete(); clr_q.delete(); fd_q.delete();
        m_bank = 0; m_in = 0; m_pix = 0; m_acq = 0; frm = 0; fd_seen = 0;
        for (int unsigned a = 0; a < DEPTH; a++) clr_q.push_back((3 << 16) | a);
    endtask

    task automatic send(input int unsigned bin);
        int unsigned w;
        w = 0;
        bus.tdc_valid = 1'b1;
        bus.tdc_bin   = NB'(bin);
        while (!bus.tdc_ready && w < 300) begin
            tick();
            w++;
        end
        if (!bus.tdc_ready) begin
            check_eq("send_ready_timeout", 32'(bus.tdc_ready), 1);
        end else begin
            if (bin < BIN_NUM) wr_q.push_back((m_bank << 16) | (m_pix * BIN_NUM + bin));
            m_in++;
            if (m_in == DATA_NUM) begin
                m_in = 0;
                m_pix++;
                if (m_pix == PIXEL_NUM) begin
                    m_pix = 0;
                    m_acq++;
                    if (m_acq == ACQ_NUM) begin
                        m_acq = 0;
                        frm++;
                        for (int unsigned a = 0; a < DEPTH; a++) begin
                            rd_q.push_back((frm << 24) | (m_bank << 16) | a);
                            clr_q.push_back((frm << 24) | ((1 << m_bank) << 16) | a);
                        end
                        fd_q.push_back(m_bank ^ 1);
                        m_bank = m_bank ^ 1;
                    end
                end
            end
            tick();
        end
        bus.tdc_valid = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned w;
        w = 0;
        while ((wr_q.size() + rd_q.size() + clr_q.size() + fd_q.size()) != 0 && w < budget) begin
            tick();
            w++;
        end
        check_eq("drain", 32'(wr_q.size() + rd_q.size() + clr_q.size() + fd_q.size()), 0);
    endtask

    task automatic wait_ready();
        int unsigned w;
        w = 0;
        while (!bus.tdc_ready && w < 100) begin
            tick();
            w++;
        end
        check_eq("init_ready", 32'(bus.tdc_ready), 1);
        check_eq("init_his_num", 32'(his_num), 0);
        check_eq("init_clr_left", 32'(clr_q.size()), 0);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!res) begin
            if (frame_done) begin
                fd_seen++;
                check_eq("fd_pulse", 32'(fd_prev), 0);
                if (fd_q.size() == 0) check_eq("fd_extra", 32'(frame_done), 0);
                else check_eq("fd_his_num", 32'(his_num), fd_q.pop_front());
                check_eq("rd_tag", (rd_q.size() != 0) ? (rd_q[0] >> 24) : 0, fd_seen);
                check_eq("clr_tag", (clr_q.size() != 0) ? (clr_q[0] >> 24) : fd_seen, fd_seen);
            end
            if (bus.wr_en) begin
                if (wr_q.size() == 0) check_eq("wr_extra", 32'(bus.wr_en), 0);
                else check_eq("wr", (32'(bus.wr_bank) << 16) | 32'(bus.wr_addr), wr_q.pop_front());
                if (bus.rd_valid) check_eq("bank_clash", 32'(bus.wr_bank == bus.rd_bank), 0);
            end
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_extra", 32'(bus.rd_valid), 0);
                end else begin
                    e = rd_q[0];
                    check_eq("rd", (32'(bus.rd_bank) << 16) | 32'(bus.rd_addr), e & 32'h00FF_FFFF);
                    check_eq("rd_last", 32'(bus.rd_last), 32'((e & 32'hFFFF) == DEPTH - 1));
                    if (bus.rd_ready) void'(rd_q.pop_front());
                end
            end
            if (bus.clr_en) begin
                if (clr_q.size() == 0) check_eq("clr_extra", 32'(bus.clr_en), 0);
                else check_eq("clr", (32'(bus.clr_mask) << 16) | 32'(bus.clr_addr),
                              clr_q.pop_front() & 32'h00FF_FFFF);
                if (bus.clr_mask == 2'b11) check_eq("init_tdc_ready", 32'(bus.tdc_ready), 0);
                else check_eq("clr_his", 32'(bus.clr_mask[his_num]), 0);
            end
        end
        fd_prev = frame_done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned w, hi;
        bus.tdc_valid = 1'b0;
        bus.tdc_bin   = '0;
        bus.rd_ready  = 1'b1;
        res = 1'b1;
        model_reset();
        repeat (3) tick();
        check_eq("reset_outs", outs(), 0);
        res = 1'b0;
        wait_ready();

        // Frame 1 into bank 0, then readout with backpressure while frame 2 fills bank 1.
        for (int i = 0; i < 12; i++) send(5);
        w = 0;
        while (fd_seen < 1 && w < 50) begin tick(); w++; end
        check_eq("fd1_seen", fd_seen, 1);
        fork
            begin
                bus.rd_ready = 1'b0;
                repeat (30) tick();
                bus.rd_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) send(6);
                hi = 0;
                w  = 0;
                while (his_num === 1'b1 && w < 300) begin
                    if (bus.tdc_ready) hi++;
                    tick();
                    w++;
                end
                check_eq("stall_ready_hi", hi, 0);
                check_eq("swap2_his_num", 32'(his_num), 0);
            end
        join
        wait_drain(300);

        // Out-of-range bin: dropped from the histogram but still counted.
        check_eq("err_bin_pre", 32'(err_bin), 0);
        send(12);
        check_eq("err_bin_set", 32'(err_bin), 1);
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(3);
        w = 0;
        while (his_num !== 1'b1 && w < 100) begin tick(); w++; end
        check_eq("swap3_his_num", 32'(his_num), 1);
        repeat (3) tick();
        check_eq("rd_held_valid", 32'(bus.rd_valid), 1);

        // Reset in the middle of a held readout.
        res = 1'b1;
        @(negedge clk);
        check_eq("midrun_reset_outs", outs(), 0);
        model_reset();
        tick();
        tick();
        bus.rd_ready = 1'b1;
        res = 1'b0;
        wait_ready();
        check_eq("err_bin_cleared", 32'(err_bin), 0);
        send(7);
        send(7);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
